add_rs_dispatch: RTL and testbench
==================================

Name: add_rs_dispatch

Overview:
- Reservation station for the add/sub functional unit, and the dispatch (initiator) side of the exec-unit interface.
- Accepts decoded add/sub ops from the issue stage into 3 entries.
- Snoops the common data bus (CDB) for pending operands.
- Selects one ready entry and dispatches it, with operands, to the add/sub execution unit.
- Frees the entry when the exec unit reports completion.
- Exports occupancy to the issue stage.

Parameters:
- NUM_RS, 3, number of reservation-station entries (index width 3 bits fixed).
- DATA_W, 8, operand/result width.
- TAG_W, 3, ROB tag width (producer tag).
- REG_W, 4, architectural destination register index width.

Ports:
- clk1  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  issue stage presents an op.
- iss_ready  out  1  free entry exists (registered-state based).
- iss_func  in  4  0000 add, 0001 sub.
- iss_rd  in  4  destination register.
- iss_rob  in  3  ROB index of this op.
- iss_s1_rdy, iss_s2_rdy  in  1 each  operand value already available.
- iss_s1_val, iss_s2_val  in  8 each  operand value (valid when rdy).
- iss_s1_tag, iss_s2_tag  in  3 each  producer ROB tag (used when not rdy).
- cdb_valid  in  1  result broadcast this cycle.
- cdb_tag  in  3  ROB tag of broadcast result.
- cdb_data  in  8  broadcast result.
- ex_valid  out  1  one-cycle dispatch pulse.
- ex_rs_index, ex_rob  out  3 each  dispatched entry index and ROB index.
- ex_func, ex_rd  out  4 each  dispatched func and destination register.
- ex_src1, ex_src2  out  8 each  operands.
- ex_done  in  1  exec unit finished the op in flight.
- ex_done_idx  in  3  entry index being completed.
- rs_count  out  2  occupied entries (0..3).
- err_func  out  1  sticky: illegal func offered.

Behaviour:
- Reset (async, rst_n=0):
  - All entries FREE, inflight=0.
  - ex_valid=0; all ex_* outputs 0.
  - rs_count=0, err_func=0; iss_ready=1 once reset is released.
- Entry fields: state, func, rd, rob, s1/s2 {rdy, val, tag}.
- Entry states:
  - FREE -> WAIT: on accept, if either operand is not ready.
  - FREE -> READY: on accept, if both operands are ready (after bypass).
  - WAIT -> READY: when both operands are ready after CDB capture.
  - READY -> EXEC: on dispatch.
  - EXEC -> FREE: on ex_done with ex_done_idx equal to the entry index.
- Accept:
  - Condition: iss_valid & iss_ready at the edge.
  - Target: lowest-index FREE entry.
  - iss_ready = any FREE entry in the registered state; an entry freed this cycle is usable next cycle only.
- Illegal func (not 0000/0001): the op is not written to any entry, err_func is set (cleared only by reset), and iss_ready is unaffected.
- CDB capture:
  - Every non-rdy operand whose tag equals cdb_tag while cdb_valid=1 latches cdb_data and sets rdy, in all WAIT entries.
- Issue/CDB bypass: if an op is accepted in the same cycle that cdb_tag matches an incoming non-ready operand tag, cdb_data is captured into the new entry.
- Dispatch select:
  - Eligible: READY entries in the registered state and inflight=0. An entry that became READY this cycle is eligible next cycle.
  - Priority: lowest index.
  - On dispatch: ex_* outputs are registered, ex_valid=1 for exactly one cycle, inflight=1.
  - Minimum latency: op accepted with both operands ready at edge N -> ex_valid high after edge N+1.
- Completion:
  - ex_done frees the entry and clears inflight at that edge.
  - A new dispatch is possible from the next edge (at most one op in flight).
  - ex_done with an index not in EXEC, or with inflight=0, is ignored.
- rs_count: registered count of non-FREE entries.
  - Accept and free in the same edge: count unchanged.
- Simultaneous accept + CDB + ex_done in one cycle: all three are applied independently. Accept never targets the entry being freed that cycle.
- Reset mid-operation: all state is discarded immediately, including any in-flight op. ex_valid drops asynchronously.

Decomposition:
- Shared package tomasulo_pkg: FUNC_ADD=4'b0000, FUNC_SUB=4'b0001, DATA_W, TAG_W, REG_W, NUM_RS, and the entry-state encoding (FREE/WAIT/READY/EXEC).
- One natural sub-module: rs_prio_sel, a lowest-index one-hot/encoded picker. It is instantiated twice: once for free-entry allocation and once for ready-entry dispatch.

Test Plan:
- Reset then issue add rd=2 rob=1, s1=5 and s2=3 both ready -> entry 0 READY; ex_valid after one more edge with ex_src1=5, ex_src2=3, ex_func=0000, ex_rs_index=0; rs_count=1; ex_done idx0 -> rs_count=0.
- Issue sub with s1 ready=9, s2 tag=4 not ready -> no dispatch; cdb_valid, tag=4, data=2 -> next cycle ex_valid with ex_src2=2, ex_func=0001.
- Issue with s2 tag=6 in the same cycle as cdb tag=6 data=7 (bypass) -> entry captured READY; dispatch with ex_src2=7.
- Fill 3 entries -> iss_ready=0 and a 4th iss_valid is dropped; ex_done idx1 -> iss_ready=1 next cycle; the next issue lands in entry 1.
- Entries 0 and 2 both READY, entry 0 dispatched -> no second ex_valid until ex_done idx0; then entry 2 dispatches.
- iss_func=0101 -> err_func=1 and rs_count unchanged; assert rst_n=0 mid-dispatch -> ex_valid=0, rs_count=0, err_func=0 immediately.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the add/sub reservation station: widths, function
// codes, entry-state encoding and the entry record layout.
package tomasulo_pkg;

  localparam int NUM_RS = 3;
  localparam int DATA_W = 8;
  localparam int TAG_W  = 3;
  localparam int REG_W  = 4;
  localparam int FUNC_W = 4;
  localparam int IDX_W  = 3;

  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } rs_state_e;

  // One source operand: either a value (rdy=1) or the ROB tag of its producer.
  typedef struct packed {
    logic              rdy;
    logic [DATA_W-1:0] val;
    logic [TAG_W-1:0]  tag;
  } rs_opnd_t;

  typedef struct packed {
    rs_state_e         state;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  rob;
    rs_opnd_t          s1;
    rs_opnd_t          s2;
  } rs_entry_t;

  function automatic logic func_legal(input logic [FUNC_W-1:0] f);
    return (f == FUNC_ADD) || (f == FUNC_SUB);
  endfunction

  // Snoop one CDB broadcast: a pending operand whose producer tag matches
  // picks up the broadcast value and becomes ready.
  function automatic rs_opnd_t opnd_capture(input rs_opnd_t         o,
                                            input logic             cdb_v,
                                            input logic [TAG_W-1:0] cdb_t,
                                            input logic [DATA_W-1:0] cdb_d);
    rs_opnd_t r;
    r = o;
    if (!o.rdy && cdb_v && (o.tag == cdb_t)) begin
      r.rdy = 1'b1;
      r.val = cdb_d;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_rs_dispatch_if.sv
// Issue, CDB and exec-unit signals of the add/sub reservation station.
// master = issue stage / CDB / exec unit side, slave = reservation station.
interface add_rs_dispatch_if;
  import tomasulo_pkg::*;

  logic              iss_valid;
  logic              iss_ready;
  logic [FUNC_W-1:0] iss_func;
  logic [REG_W-1:0]  iss_rd;
  logic [TAG_W-1:0]  iss_rob;
  logic              iss_s1_rdy;
  logic              iss_s2_rdy;
  logic [DATA_W-1:0] iss_s1_val;
  logic [DATA_W-1:0] iss_s2_val;
  logic [TAG_W-1:0]  iss_s1_tag;
  logic [TAG_W-1:0]  iss_s2_tag;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              ex_valid;
  logic [IDX_W-1:0]  ex_rs_index;
  logic [TAG_W-1:0]  ex_rob;
  logic [FUNC_W-1:0] ex_func;
  logic [REG_W-1:0]  ex_rd;
  logic [DATA_W-1:0] ex_src1;
  logic [DATA_W-1:0] ex_src2;
  logic              ex_done;
  logic [IDX_W-1:0]  ex_done_idx;

  logic [1:0]        rs_count;
  logic              err_func;

  modport master (
    output iss_valid, iss_func, iss_rd, iss_rob,
           iss_s1_rdy, iss_s2_rdy, iss_s1_val, iss_s2_val, iss_s1_tag, iss_s2_tag,
           cdb_valid, cdb_tag, cdb_data, ex_done, ex_done_idx,
    input  iss_ready, ex_valid, ex_rs_index, ex_rob, ex_func, ex_rd,
           ex_src1, ex_src2, rs_count, err_func
  );

  modport slave (
    input  iss_valid, iss_func, iss_rd, iss_rob,
           iss_s1_rdy, iss_s2_rdy, iss_s1_val, iss_s2_val, iss_s1_tag, iss_s2_tag,
           cdb_valid, cdb_tag, cdb_data, ex_done, ex_done_idx,
    output iss_ready, ex_valid, ex_rs_index, ex_rob, ex_func, ex_rd,
           ex_src1, ex_src2, rs_count, err_func
  );

endinterface

// File: rtl/add_rs_dispatch_rs_prio_sel.sv
// Lowest-index picker: one-hot grant internally, exported as an encoded
// index plus a "something requested" flag.
module rs_prio_sel #(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  output logic [2:0]   idx_o,
  output logic         vld_o
);

  logic [N-1:0] gnt_oh;

  // Each bit wins only if no lower-index request is present.
  for (genvar gi = 0; gi < N; gi++) begin : g_pick
    localparam logic [N-1:0] LOWER = N'((1 << gi) - 1);
    assign gnt_oh[gi] = req_i[gi] & ~|(req_i & LOWER);
  end

  assign vld_o = |req_i;

  // Encode the one-hot grant.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_oh[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/add_rs_dispatch.sv
// Add/sub reservation station with dispatch to a single exec unit.
// Entries allocate lowest-free, snoop the CDB for pending operands, and the
// lowest READY entry dispatches whenever nothing is in flight.
module add_rs_dispatch
  import tomasulo_pkg::*;
(
  input logic             clk1,
  input logic             rst_n,
  add_rs_dispatch_if.slave bus
);

  rs_entry_t entry_q [NUM_RS];
  rs_entry_t entry_d [NUM_RS];

  logic              inflight_q, inflight_d;
  logic [1:0]        rs_count_q, rs_count_d;
  logic              err_func_q;

  logic              ex_valid_q;
  logic [IDX_W-1:0]  ex_rs_index_q;
  logic [TAG_W-1:0]  ex_rob_q;
  logic [FUNC_W-1:0] ex_func_q;
  logic [REG_W-1:0]  ex_rd_q;
  logic [DATA_W-1:0] ex_src1_q;
  logic [DATA_W-1:0] ex_src2_q;

  logic [NUM_RS-1:0] free_vec;
  logic [NUM_RS-1:0] ready_vec;
  logic [NUM_RS-1:0] done_hit;
  logic [IDX_W-1:0]  alloc_idx;
  logic [IDX_W-1:0]  disp_idx;
  logic              any_free;
  logic              any_ready;
  logic              accept;
  logic              dispatch;

  rs_opnd_t          raw_s1, raw_s2;
  rs_opnd_t          new_s1, new_s2;

  logic [FUNC_W-1:0] sel_func;
  logic [REG_W-1:0]  sel_rd;
  logic [TAG_W-1:0]  sel_rob;
  logic [DATA_W-1:0] sel_src1;
  logic [DATA_W-1:0] sel_src2;

  // Per-entry status decoded from registered state only, so an entry freed
  // or readied this cycle becomes usable on the following cycle.
  for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_status
    assign free_vec[gi]  = (entry_q[gi].state == ST_FREE);
    assign ready_vec[gi] = (entry_q[gi].state == ST_READY);
    assign done_hit[gi]  = bus.ex_done & inflight_q &
                           (bus.ex_done_idx == IDX_W'(gi)) &
                           (entry_q[gi].state == ST_EXEC);
  end

  rs_prio_sel #(.N(NUM_RS)) u_alloc_sel (
    .req_i (free_vec),
    .idx_o (alloc_idx),
    .vld_o (any_free)
  );

  rs_prio_sel #(.N(NUM_RS)) u_disp_sel (
    .req_i (ready_vec),
    .idx_o (disp_idx),
    .vld_o (any_ready)
  );

  // Illegal funcs are never written; they only raise the sticky error.
  assign accept   = bus.iss_valid & any_free & func_legal(bus.iss_func);
  assign dispatch = any_ready & ~inflight_q;

  // Incoming operands see the same-cycle CDB broadcast (issue/CDB bypass).
  assign raw_s1 = {bus.iss_s1_rdy, bus.iss_s1_val, bus.iss_s1_tag};
  assign raw_s2 = {bus.iss_s2_rdy, bus.iss_s2_val, bus.iss_s2_tag};
  assign new_s1 = opnd_capture(raw_s1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  assign new_s2 = opnd_capture(raw_s2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

  // Entry lifecycle: allocate, capture CDB, dispatch, complete.
  always_comb begin
    for (int i = 0; i < NUM_RS; i++) begin
      entry_d[i] = entry_q[i];
      case (entry_q[i].state)
        ST_FREE: begin
          if (accept && (alloc_idx == IDX_W'(i))) begin
            entry_d[i].func  = bus.iss_func;
            entry_d[i].rd    = bus.iss_rd;
            entry_d[i].rob   = bus.iss_rob;
            entry_d[i].s1    = new_s1;
            entry_d[i].s2    = new_s2;
            entry_d[i].state = (new_s1.rdy && new_s2.rdy) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          entry_d[i].s1 = opnd_capture(entry_q[i].s1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
          entry_d[i].s2 = opnd_capture(entry_q[i].s2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
          if (entry_d[i].s1.rdy && entry_d[i].s2.rdy) entry_d[i].state = ST_READY;
        end
        ST_READY: begin
          if (dispatch && (disp_idx == IDX_W'(i))) entry_d[i].state = ST_EXEC;
        end
        ST_EXEC: begin
          if (done_hit[i]) entry_d[i].state = ST_FREE;
        end
        default: ;
      endcase
    end
  end

  // Next occupancy count and the fields of the entry chosen for dispatch.
  always_comb begin
    rs_count_d = '0;
    sel_func   = '0;
    sel_rd     = '0;
    sel_rob    = '0;
    sel_src1   = '0;
    sel_src2   = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (entry_d[i].state != ST_FREE) rs_count_d = rs_count_d + 2'd1;
      if (disp_idx == IDX_W'(i)) begin
        sel_func = entry_q[i].func;
        sel_rd   = entry_q[i].rd;
        sel_rob  = entry_q[i].rob;
        sel_src1 = entry_q[i].s1.val;
        sel_src2 = entry_q[i].s2.val;
      end
    end
  end

  // At most one op in flight: set on dispatch, cleared by a valid completion.
  assign inflight_d = (inflight_q & ~|done_hit) | dispatch;

  // Entry storage.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RS; i++) entry_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RS; i++) entry_q[i] <= entry_d[i];
    end
  end

  // Control state and registered exec-unit outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q    <= 1'b0;
      rs_count_q    <= '0;
      err_func_q    <= 1'b0;
      ex_valid_q    <= 1'b0;
      ex_rs_index_q <= '0;
      ex_rob_q      <= '0;
      ex_func_q     <= '0;
      ex_rd_q       <= '0;
      ex_src1_q     <= '0;
      ex_src2_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      rs_count_q <= rs_count_d;
      if (bus.iss_valid && !func_legal(bus.iss_func)) err_func_q <= 1'b1;
      ex_valid_q <= dispatch;
      if (dispatch) begin
        ex_rs_index_q <= disp_idx;
        ex_rob_q      <= sel_rob;
        ex_func_q     <= sel_func;
        ex_rd_q       <= sel_rd;
        ex_src1_q     <= sel_src1;
        ex_src2_q     <= sel_src2;
      end
    end
  end

  assign bus.iss_ready   = any_free;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_rs_index = ex_rs_index_q;
  assign bus.ex_rob      = ex_rob_q;
  assign bus.ex_func     = ex_func_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_src1     = ex_src1_q;
  assign bus.ex_src2     = ex_src2_q;
  assign bus.rs_count    = rs_count_q;
  assign bus.err_func    = err_func_q;

endmodule

// File: tb/tb_add_rs_dispatch.sv
// Bench for add_rs_dispatch: directed vector table, hand-written multi-cycle
// sequences, then random traffic checked against a slot-level model.
module tb_add_rs_dispatch;
  import tomasulo_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_rs_dispatch_if bus();

  add_rs_dispatch dut (
    .clk1  (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic iv; logic [3:0] fn; logic [3:0] rd; logic [2:0] rob;
    logic r1; logic [7:0] v1; logic [2:0] t1;
    logic r2; logic [7:0] v2; logic [2:0] t2;
    logic cv; logic [2:0] ct; logic [7:0] cd;
    logic dn; logic [2:0] di;
    logic ev; logic [2:0] eidx; logic [3:0] efn; logic [3:0] erd; logic [2:0] erob;
    logic [7:0] es1; logic [7:0] es2; logic [1:0] ecnt; logic erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t V(
    input logic iv, input logic [3:0] fn, input logic [3:0] rd, input logic [2:0] rob,
    input logic r1, input logic [7:0] v1, input logic [2:0] t1,
    input logic r2, input logic [7:0] v2, input logic [2:0] t2,
    input logic cv, input logic [2:0] ct, input logic [7:0] cd,
    input logic dn, input logic [2:0] di,
    input logic ev, input logic [2:0] eidx, input logic [3:0] efn, input logic [3:0] erd,
    input logic [2:0] erob, input logic [7:0] es1, input logic [7:0] es2,
    input logic [1:0] ecnt, input logic erdy);
    vec_t v;
    v.iv = iv; v.fn = fn; v.rd = rd; v.rob = rob;
    v.r1 = r1; v.v1 = v1; v.t1 = t1; v.r2 = r2; v.v2 = v2; v.t2 = t2;
    v.cv = cv; v.ct = ct; v.cd = cd; v.dn = dn; v.di = di;
    v.ev = ev; v.eidx = eidx; v.efn = efn; v.erd = erd; v.erob = erob;
    v.es1 = es1; v.es2 = es2; v.ecnt = ecnt; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 0; bus.iss_func = 0; bus.iss_rd = 0; bus.iss_rob = 0;
    bus.iss_s1_rdy = 0; bus.iss_s1_val = 0; bus.iss_s1_tag = 0;
    bus.iss_s2_rdy = 0; bus.iss_s2_val = 0; bus.iss_s2_tag = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
    bus.ex_done = 0; bus.ex_done_idx = 0;
  endtask

  task automatic issue(input logic [3:0] fn, input logic [3:0] rd, input logic [2:0] rob,
                       input logic r1, input logic [7:0] v1, input logic [2:0] t1,
                       input logic r2, input logic [7:0] v2, input logic [2:0] t2);
    bus.iss_valid = 1; bus.iss_func = fn; bus.iss_rd = rd; bus.iss_rob = rob;
    bus.iss_s1_rdy = r1; bus.iss_s1_val = v1; bus.iss_s1_tag = t1;
    bus.iss_s2_rdy = r2; bus.iss_s2_val = v2; bus.iss_s2_tag = t2;
  endtask

  task automatic drive(input vec_t v);
    bus.iss_valid = v.iv; bus.iss_func = v.fn; bus.iss_rd = v.rd; bus.iss_rob = v.rob;
    bus.iss_s1_rdy = v.r1; bus.iss_s1_val = v.v1; bus.iss_s1_tag = v.t1;
    bus.iss_s2_rdy = v.r2; bus.iss_s2_val = v.v2; bus.iss_s2_tag = v.t2;
    bus.cdb_valid = v.cv; bus.cdb_tag = v.ct; bus.cdb_data = v.cd;
    bus.ex_done = v.dn; bus.ex_done_idx = v.di;
  endtask

  // Checks one dispatched op's full payload.
  task automatic chk_disp(input string nm, input logic [2:0] idx, input logic [3:0] fn,
                          input logic [3:0] rd, input logic [2:0] rob,
                          input logic [7:0] s1, input logic [7:0] s2);
    chk({nm, "_ex_valid"}, 32'(bus.ex_valid), 32'(1));
    chk({nm, "_ex_payload"},
        32'({bus.ex_rs_index, bus.ex_func, bus.ex_rd, bus.ex_rob, bus.ex_src1, bus.ex_src2}),
        32'({idx, fn, rd, rob, s1, s2}));
  endtask

  // ---------------- slot-level reference model ----------------
  // A slot is "busy" from accept until completion; it may go to the exec
  // unit once it holds both operand values and nothing else is executing.
  bit         m_busy [3];
  bit         m_h1 [3], m_h2 [3];
  logic [7:0] m_v1 [3], m_v2 [3];
  logic [2:0] m_t1 [3], m_t2 [3];
  logic [3:0] m_fn [3], m_rd [3];
  logic [2:0] m_rob [3];
  int         m_exec;
  bit         m_err;
  bit         e_valid;
  logic [29:0] e_payload;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_h1[i] = 0; m_h2[i] = 0;
    end
    m_exec = -1; m_err = 0; e_valid = 0; e_payload = '0;
  endtask

  task automatic model_edge();
    int  fs, go;
    bit  legal;
    fs = -1; go = -1;
    for (int i = 0; i < 3; i++) if (!m_busy[i] && fs < 0) fs = i;
    if (m_exec < 0)
      for (int i = 0; i < 3; i++) if (m_busy[i] && m_h1[i] && m_h2[i] && go < 0) go = i;
    e_valid = (go >= 0);
    if (go >= 0)
      e_payload = {3'(go), m_fn[go], m_rd[go], m_rob[go], m_v1[go], m_v2[go]};
    if (bus.ex_done && m_exec >= 0 && int'(bus.ex_done_idx) == m_exec) begin
      m_busy[m_exec] = 0;
      m_exec = -1;
    end
    if (go >= 0) m_exec = go;
    if (bus.cdb_valid)
      for (int i = 0; i < 3; i++) if (m_busy[i]) begin
        if (!m_h1[i] && m_t1[i] == bus.cdb_tag) begin m_h1[i] = 1; m_v1[i] = bus.cdb_data; end
        if (!m_h2[i] && m_t2[i] == bus.cdb_tag) begin m_h2[i] = 1; m_v2[i] = bus.cdb_data; end
      end
    legal = (bus.iss_func == 4'd0) || (bus.iss_func == 4'd1);
    if (bus.iss_valid && !legal) m_err = 1;
    if (bus.iss_valid && legal && fs >= 0) begin
      m_busy[fs] = 1;
      m_fn[fs] = bus.iss_func; m_rd[fs] = bus.iss_rd; m_rob[fs] = bus.iss_rob;
      m_t1[fs] = bus.iss_s1_tag; m_t2[fs] = bus.iss_s2_tag;
      m_h1[fs] = bus.iss_s1_rdy || (bus.cdb_valid && bus.iss_s1_tag == bus.cdb_tag);
      m_v1[fs] = bus.iss_s1_rdy ? bus.iss_s1_val : bus.cdb_data;
      m_h2[fs] = bus.iss_s2_rdy || (bus.cdb_valid && bus.iss_s2_tag == bus.cdb_tag);
      m_v2[fs] = bus.iss_s2_rdy ? bus.iss_s2_val : bus.cdb_data;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 3; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  initial begin
    idle();
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'(0));
    chk("rst_ex_fields", 32'({bus.ex_rs_index, bus.ex_func, bus.ex_rd, bus.ex_rob,
                              bus.ex_src1, bus.ex_src2}), 32'(0));
    chk("rst_rs_count", 32'(bus.rs_count), 32'(0));
    chk("rst_err_func", 32'(bus.err_func), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_iss_ready", 32'(bus.iss_ready), 32'(1));

    // ---------------- directed vector table ----------------
    //             iv fn rd rob r1 v1 t1 r2 v2 t2 cv ct cd dn di  ev ix fn rd rob s1 s2 cnt rdy
    vecs.push_back(V(1, 0, 2, 1, 1, 5, 0, 1, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 2, 1,  5, 3, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1));
    vecs.push_back(V(1, 1, 3, 2, 1, 9, 0, 0, 0, 4, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 2, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 3, 2,  9, 2, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1));
    vecs.push_back(V(1, 0, 5, 3, 1, 4, 0, 0, 0, 6, 1, 6, 7, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 5, 3,  4, 7, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1));
    vecs.push_back(V(1, 0, 6, 4, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 99, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 10, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 6, 4, 10, 1, 1, 1));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 1));

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k]);
      tick();
      $display("vec %0d: ex_valid=%0d rs_count=%0d iss_ready=%0d", k,
               bus.ex_valid, bus.rs_count, bus.iss_ready);
      chk($sformatf("vec%0d_ex_valid", k), 32'(bus.ex_valid), 32'(vecs[k].ev));
      chk($sformatf("vec%0d_rs_count", k), 32'(bus.rs_count), 32'(vecs[k].ecnt));
      chk($sformatf("vec%0d_iss_ready", k), 32'(bus.iss_ready), 32'(vecs[k].erdy));
      chk($sformatf("vec%0d_err_func", k), 32'(bus.err_func), 32'(0));
      if (vecs[k].ev)
        chk($sformatf("vec%0d_ex_payload", k),
            32'({bus.ex_rs_index, bus.ex_func, bus.ex_rd, bus.ex_rob, bus.ex_src1, bus.ex_src2}),
            32'({vecs[k].eidx, vecs[k].efn, vecs[k].erd, vecs[k].erob, vecs[k].es1, vecs[k].es2}));
    end

    // ---------------- fill / drop / reuse freed entry ----------------
    idle(); issue(0, 1, 1, 0, 0, 7, 1, 1, 0); tick();        // entry0 waits on tag 7
    chk("fill_cnt1", 32'(bus.rs_count), 32'(1));
    idle(); issue(1, 2, 2, 1, 50, 0, 1, 8, 0); tick();       // entry1 ready
    chk("fill_cnt2", 32'(bus.rs_count), 32'(2));
    idle(); issue(0, 3, 3, 1, 3, 0, 0, 0, 7); tick();        // entry2 waits; entry1 dispatches
    $display("seq fill: entry1 dispatch idx=%0d", bus.ex_rs_index);
    chk_disp("fill_e1", 1, 1, 2, 2, 50, 8);
    chk("fill_cnt3", 32'(bus.rs_count), 32'(3));
    chk("fill_not_ready", 32'(bus.iss_ready), 32'(0));
    idle(); issue(1, 15, 7, 1, 77, 0, 1, 66, 0); tick();     // full: dropped
    chk("drop_cnt", 32'(bus.rs_count), 32'(3));
    chk("drop_ex_valid", 32'(bus.ex_valid), 32'(0));
    idle(); bus.ex_done = 1; bus.ex_done_idx = 1; tick();
    chk("free1_cnt", 32'(bus.rs_count), 32'(2));
    chk("free1_ready", 32'(bus.iss_ready), 32'(1));
    idle(); issue(0, 9, 5, 1, 11, 0, 1, 12, 0); tick();      // must land in entry1
    chk("reuse_cnt", 32'(bus.rs_count), 32'(3));
    idle(); tick();
    chk_disp("reuse_e1", 1, 0, 9, 5, 11, 12);

    // ---------------- one op in flight ----------------
    idle(); bus.ex_done = 1; bus.ex_done_idx = 1;
    bus.cdb_valid = 1; bus.cdb_tag = 7; bus.cdb_data = 20; tick();   // entries 0 and 2 ready
    chk("oneop_cnt2", 32'(bus.rs_count), 32'(2));
    idle(); tick();
    chk_disp("oneop_e0", 0, 0, 1, 1, 20, 1);
    tick();
    chk("oneop_hold_a", 32'(bus.ex_valid), 32'(0));
    tick();
    chk("oneop_hold_b", 32'(bus.ex_valid), 32'(0));
    bus.ex_done = 1; bus.ex_done_idx = 0; tick();
    chk("oneop_done_ev", 32'(bus.ex_valid), 32'(0));
    chk("oneop_done_cnt", 32'(bus.rs_count), 32'(1));
    idle(); tick();
    chk_disp("oneop_e2", 2, 0, 3, 3, 3, 20);
    bus.ex_done = 1; bus.ex_done_idx = 2; tick();
    chk("oneop_empty", 32'(bus.rs_count), 32'(0));

    // ---------------- illegal func, then reset mid-dispatch ----------------
    idle(); issue(4'b0101, 1, 1, 1, 1, 0, 1, 1, 0); tick();
    $display("seq illegal: err_func=%0d rs_count=%0d", bus.err_func, bus.rs_count);
    chk("illegal_err", 32'(bus.err_func), 32'(1));
    chk("illegal_cnt", 32'(bus.rs_count), 32'(0));
    chk("illegal_ready", 32'(bus.iss_ready), 32'(1));
    idle(); issue(0, 7, 6, 1, 33, 0, 1, 44, 0); tick();
    chk("pre_rst_cnt", 32'(bus.rs_count), 32'(1));
    idle(); tick();
    chk_disp("pre_rst", 0, 0, 7, 6, 33, 44);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ex_valid", 32'(bus.ex_valid), 32'(0));
    chk("async_rst_cnt", 32'(bus.rs_count), 32'(0));
    chk("async_rst_err", 32'(bus.err_func), 32'(0));
    chk("async_rst_src", 32'({bus.ex_src1, bus.ex_src2}), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ex_valid", 32'(bus.ex_valid), 32'(0));
    chk("post_rst_cnt", 32'(bus.rs_count), 32'(0));

    // ---------------- random traffic vs model ----------------
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      bus.iss_valid  = ($urandom_range(0, 2) != 0);
      bus.iss_func   = 4'($urandom_range(0, 1));
      bus.iss_rd     = 4'($urandom);
      bus.iss_rob    = 3'($urandom);
      bus.iss_s1_rdy = 1'($urandom);
      bus.iss_s1_val = 8'($urandom);
      bus.iss_s1_tag = 3'($urandom);
      bus.iss_s2_rdy = 1'($urandom);
      bus.iss_s2_val = 8'($urandom);
      bus.iss_s2_tag = 3'($urandom);
      bus.cdb_valid  = 1'($urandom);
      bus.cdb_tag    = 3'($urandom);
      bus.cdb_data   = 8'($urandom);
      if (m_exec >= 0 && $urandom_range(0, 2) == 0) begin
        bus.ex_done     = 1;
        bus.ex_done_idx = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'(m_exec);
      end else if ($urandom_range(0, 7) == 0) begin
        bus.ex_done     = 1;
        bus.ex_done_idx = 3'($urandom);
      end
      model_edge();
      tick();
      if (e_valid)
        $display("rand %0d: dispatch idx=%0d src1=%0d src2=%0d", cyc,
                 bus.ex_rs_index, bus.ex_src1, bus.ex_src2);
      chk("rand_ex_valid", 32'(bus.ex_valid), 32'(e_valid));
      if (e_valid)
        chk("rand_ex_payload",
            32'({bus.ex_rs_index, bus.ex_func, bus.ex_rd, bus.ex_rob, bus.ex_src1, bus.ex_src2}),
            32'(e_payload));
      chk("rand_rs_count", 32'(bus.rs_count), 32'(model_count()));
      chk("rand_iss_ready", 32'(bus.iss_ready), 32'(model_count() < 3));
      chk("rand_err_func", 32'(bus.err_func), 32'(m_err));
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
